tiled_iter_ctrl: RTL

//  Sequences row loads and multi-lane column issues for the matrix multiplier over runtime-configured dims.

---
 rtl/mm_pkg.sv | 20 ++
 rtl/iter_outst_cnt.sv | 33 +++
 rtl/tiled_iter_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared types and width helpers for the tiled matrix-multiply iteration controller.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } iter_state_t;

  function automatic int row_w(input int max_rows);
    return (max_rows <= 1) ? 1 : $clog2(max_rows);
  endfunction

  function automatic int col_w(input int max_cols);
    return (max_cols <= 1) ? 1 : $clog2(max_cols);
  endfunction

endpackage

// File: rtl/iter_outst_cnt.sv
// Up/down counter of issued-but-unretired column groups, with full/empty flags.
module iter_outst_cnt #(
  parameter int  MAX_OUTST = 8,
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [CNT_W-1:0] cnt;

  // Simultaneous inc and dec cancel; clear wins over both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign full  = (cnt == CNT_W'(MAX_OUTST));
  assign empty = (cnt == '0);

endmodule

// File: rtl/tiled_iter_ctrl.sv
// Row-load / multi-lane column-issue sequencer for the matrix multiplier.
// Optional ITER_PERF_CNT_EN adds the stall_cycles performance counter port.
module tiled_iter_ctrl
  import mm_pkg::*;
#(
  parameter int  MAX_ROWS  = 16,
  parameter int  MAX_COLS  = 16,
  parameter int  LANES     = 4,
  parameter int  MAX_OUTST = 8,
  localparam int ROW_W     = row_w(MAX_ROWS),
  localparam int COL_W     = col_w(MAX_COLS),
  localparam int RCFG_W    = $clog2(MAX_ROWS + 1),
  localparam int CCFG_W    = $clog2(MAX_COLS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [RCFG_W-1:0] cfg_rows,
  input  logic [CCFG_W-1:0] cfg_cols,
  input  logic              mem_stall,
  input  logic              fifo_full,
  output logic              load_valid,
  input  logic              load_ready,
  output logic [ROW_W-1:0]  row_idx,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [COL_W-1:0]  col_base,
  output logic [LANES-1:0]  lane_mask,
  input  logic              retire,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef ITER_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  iter_state_t       state;
  logic [RCFG_W-1:0] rows_q;
  logic [CCFG_W-1:0] cols_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              outst_full;
  logic              outst_empty;
  logic              start_acc;
  logic              abort_acc;
  logic              load_hs;
  logic              issue_hs;
  logic              last_row;
  logic              last_grp;
  logic [31:0]       col_end;

  assign start_acc   = (state == IDLE) & start & ~mem_stall;
  assign abort_acc   = (state != IDLE) & abort;
  assign load_valid  = (state == LOAD) & ~mem_stall;
  assign issue_valid = (state == ISSUE) & ~mem_stall & ~fifo_full & ~outst_full;
  assign load_hs     = load_valid & load_ready;
  assign issue_hs    = issue_valid & issue_ready;

  // Group end is computed wide so a partial last group never wraps.
  assign col_end  = 32'(col_q) + 32'(LANES);
  assign last_grp = (col_end >= 32'(cols_q));
  assign last_row = ((32'(row_q) + 32'd1) >= 32'(rows_q));

  assign row_idx  = row_q;
  assign col_base = col_q;
  assign busy     = (state != IDLE);

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = ((32'(col_q) + 32'(i)) < 32'(cols_q));
    end
  end

  iter_outst_cnt #(
    .MAX_OUTST(MAX_OUTST)
  ) u_outst (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_acc | abort_acc),
    .inc  (issue_hs),
    .dec  (retire & ~outst_empty),
    .full (outst_full),
    .empty(outst_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      aborted <= 1'b0;
      if (abort_acc) begin
        state   <= IDLE;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_acc) begin
              rows_q <= cfg_rows;
              cols_q <= cfg_cols;
              row_q  <= '0;
              col_q  <= '0;
              done   <= 1'b0;
              state  <= (cfg_rows == '0 || cfg_cols == '0) ? DONE : LOAD;
            end
          end
          LOAD: begin
            if (load_hs) begin
              col_q <= '0;
              state <= ISSUE;
            end
          end
          ISSUE: begin
            if (issue_hs) begin
              if (!last_grp) begin
                col_q <= col_end[COL_W-1:0];
              end else if (last_row) begin
                state <= DRAIN;
              end else begin
                row_q <= row_q + ROW_W'(1);
                state <= LOAD;
              end
            end
          end
          DRAIN: begin
            if (outst_empty) begin
              state <= DONE;
            end
          end
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ITER_PERF_CNT_EN
  // Counts LOAD/ISSUE cycles that did not complete a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (start_acc) begin
      stall_cycles <= '0;
    end else if (((state == LOAD && !load_hs) || (state == ISSUE && !issue_hs)) &&
                 (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
